// File: rtl/bht_assoc.sv
// Set-associative branch history table.
// - IF: combinational lookup gives the prediction and the predicted target.
// - ID: a branch or jump that misses is allocated into the set's FIFO victim way.
// - EXE: the branch outcome is resolved, a correction is selected and the
//   saturating counter of a hitting entry is updated.
module bht_assoc #(
    parameter int PC_W     = 10,
    parameter int SET_BITS = 4,
    parameter int WAY_BITS = 2,
    parameter int CTR_W    = 2,
    parameter int PC_STEP  = 1
) (
    input  logic            CLK,
    input  logic            rst,
    // fetch
    input  logic [PC_W-1:0] if_PC,
    output logic            if_prediction,
    output logic            if_hit,
    output logic [PC_W-1:0] if_PBT,
    // decode
    input  logic [PC_W-1:0] id_PC,
    input  logic [PC_W-1:0] id_branchtarget,
    input  logic            id_is_btype,
    input  logic            id_is_jump,
    input  logic            id_stall,
    // execute
    input  logic [PC_W-1:0] exe_PC,
    input  logic            exe_valid,
    input  logic            exe_pred_taken,
    input  logic [PC_W-1:0] exe_target,
    input  logic            exe_z,
    input  logic            exe_less,
    input  logic [5:0]      exe_btype,
    output logic [1:0]      exe_correction,
    output logic [PC_W-1:0] exe_PBT,
    output logic [PC_W-1:0] exe_CNI,
    output logic            flush
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int WAYS  = 1 << WAY_BITS;
    localparam int TAG_W = PC_W - SET_BITS;
    localparam int PTR_W = (WAY_BITS > 0) ? WAY_BITS : 1;

    // Saturation limit and the weak not-taken start value (MSB clear, rest set).
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_MAX >> 1;

    typedef struct packed {
        logic             hit;
        logic [PTR_W-1:0] way;
    } lookup_t;

    // Table storage: valid bits and FIFO pointers are reset, the payload is not.
    logic [WAYS-1:0]  valid_q    [SETS];
    logic [TAG_W-1:0] tag_q      [SETS][WAYS];
    logic [PC_W-1:0]  target_q   [SETS][WAYS];
    logic [CTR_W-1:0] ctr_q      [SETS][WAYS];
    logic [PTR_W-1:0] fifo_ptr_q [SETS];

    // Search one set for a tag; the lowest matching way wins.
    function automatic lookup_t lookup(input logic [SET_BITS-1:0] set,
                                       input logic [TAG_W-1:0]    tag);
        lookup_t r;
        r = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[set][w[PTR_W-1:0]] && tag_q[set][w[PTR_W-1:0]] == tag) begin
                r.hit = 1'b1;
                r.way = w[PTR_W-1:0];
            end
        end
        return r;
    endfunction

    logic [SET_BITS-1:0] if_set, id_set, exe_set;
    logic [TAG_W-1:0]    if_tag, id_tag, exe_tag;
    lookup_t             if_lk, id_lk, exe_lk;

    assign if_set  = if_PC[SET_BITS-1:0];
    assign if_tag  = if_PC[PC_W-1:SET_BITS];
    assign id_set  = id_PC[SET_BITS-1:0];
    assign id_tag  = id_PC[PC_W-1:SET_BITS];
    assign exe_set = exe_PC[SET_BITS-1:0];
    assign exe_tag = exe_PC[PC_W-1:SET_BITS];

    // Zero-latency lookups for the three pipeline stages.
    always_comb begin
        if_lk  = lookup(if_set, if_tag);
        id_lk  = lookup(id_set, id_tag);
        exe_lk = lookup(exe_set, exe_tag);
    end

    // IF outputs: prediction and target only when the tag hits.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        if_hit        = if_lk.hit;
        if_prediction = 1'b0;
        if_PBT        = '0;
        if (if_lk.hit) begin
            if_prediction = ctr_q[if_set][if_lk.way][CTR_W-1];
            if_PBT        = target_q[if_set][if_lk.way];
        end
    end

    // Branch resolution; exe_btype is {beq,bne,blt,bge,bltu,bgeu}.
    logic exe_active;
    logic feedback;

    assign exe_active = exe_valid && (|exe_btype);
    assign feedback   = (exe_btype[5] &&  exe_z)    ||
                        (exe_btype[4] && !exe_z)    ||
                        (exe_btype[3] &&  exe_less) ||
                        (exe_btype[2] && !exe_less) ||
                        (exe_btype[1] &&  exe_less) ||
                        (exe_btype[0] && !exe_less);

    // Correction select: redirect only when the piped prediction was wrong.
    always_comb begin
        exe_correction = 2'b00;
        if (exe_active && (exe_pred_taken != feedback))
            exe_correction = feedback ? 2'b11 : 2'b10;
    end

    assign flush   = exe_correction[1];
    assign exe_PBT = exe_target;
    assign exe_CNI = exe_PC + PC_W'(PC_STEP);

    // Write control for ID allocation and EXE counter update.
    logic             alloc_en;
    logic [PTR_W-1:0] alloc_way;
    logic [PTR_W-1:0] ptr_next;
    logic [CTR_W-1:0] alloc_ctr;
    logic             upd_en;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_next;

    assign alloc_en  = (id_is_btype || id_is_jump) && !id_stall && !id_lk.hit;
    assign alloc_way = fifo_ptr_q[id_set];
    assign ptr_next  = (alloc_way == PTR_W'(WAYS - 1)) ? '0 : alloc_way + PTR_W'(1);
    // A branch starts weakly not-taken even if it is also flagged as a jump.
    assign alloc_ctr = id_is_btype ? CTR_WNT : CTR_MAX;

    // Allocation into the very entry EXE is updating wins; the update is dropped.
    assign upd_en  = exe_active && exe_lk.hit &&
                     !(alloc_en && (id_set == exe_set) && (alloc_way == exe_lk.way));
    assign ctr_cur = ctr_q[exe_set][exe_lk.way];

    // Saturating counter step toward the resolved direction.
    always_comb begin
        ctr_next = ctr_cur;
        if (feedback && ctr_cur != CTR_MAX)
            ctr_next = ctr_cur + CTR_W'(1);
        else if (!feedback && ctr_cur != '0)
            ctr_next = ctr_cur - CTR_W'(1);
    end

    // Control state: valid bits and FIFO pointers, cleared by reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            valid_q    <= '{default: '0};
            fifo_ptr_q <= '{default: '0};
        end else if (alloc_en) begin
            valid_q[id_set][alloc_way] <= 1'b1;
            fifo_ptr_q[id_set]         <= ptr_next;
        end
    end

    // Payload arrays: tag/target/counter writes, suppressed while in reset.
    always_ff @(posedge CLK) begin
        // NOTE: the payload is deliberately not reset; valid bits guard it, and
        // leaving it reset-free lets it map onto plain RAM.
        if (!rst) begin
            if (upd_en)
                ctr_q[exe_set][exe_lk.way] <= ctr_next;
            if (alloc_en) begin
                tag_q[id_set][alloc_way]    <= id_tag;
                target_q[id_set][alloc_way] <= id_branchtarget;
                ctr_q[id_set][alloc_way]    <= alloc_ctr;
            end
        end
    end

endmodule

// File: tb/tb_bht_assoc.sv
// Self-checking bench for bht_assoc: a table of single-cycle vectors followed by
// hand-written FIFO-replacement, collision and reset sequences.
module tb_bht_assoc;

    logic       CLK = 1'b0;
    logic       rst;
    logic [9:0] if_PC, id_PC, id_branchtarget, exe_PC, exe_target;
    logic       id_is_btype, id_is_jump, id_stall;
    logic       exe_valid, exe_pred_taken, exe_z, exe_less;
    logic [5:0] exe_btype;
    logic       if_prediction, if_hit, flush;
    logic [9:0] if_PBT, exe_PBT, exe_CNI;
    logic [1:0] exe_correction;

    always #5 CLK = ~CLK;

    bht_assoc dut (
        .CLK(CLK), .rst(rst),
        .if_PC(if_PC), .if_prediction(if_prediction), .if_hit(if_hit), .if_PBT(if_PBT),
        .id_PC(id_PC), .id_branchtarget(id_branchtarget), .id_is_btype(id_is_btype),
        .id_is_jump(id_is_jump), .id_stall(id_stall),
        .exe_PC(exe_PC), .exe_valid(exe_valid), .exe_pred_taken(exe_pred_taken),
        .exe_target(exe_target), .exe_z(exe_z), .exe_less(exe_less), .exe_btype(exe_btype),
        .exe_correction(exe_correction), .exe_PBT(exe_PBT), .exe_CNI(exe_CNI), .flush(flush)
    );

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b100000;
    localparam logic [5:0] BNE  = 6'b010000;
    localparam logic [5:0] BLT  = 6'b001000;
    localparam logic [5:0] BGE  = 6'b000100;
    localparam logic [5:0] BLTU = 6'b000010;
    localparam logic [5:0] BGEU = 6'b000001;

    typedef struct {
        logic [9:0] if_pc;
        logic [9:0] id_pc;
        logic [9:0] id_tgt;
        logic       id_b;
        logic       id_j;
        logic       id_st;
        logic       ev;
        logic [9:0] epc;
        logic       ep;
        logic [9:0] etgt;
        logic       z;
        logic       less;
        logic [5:0] bt;
        logic       e_hit;
        logic       e_pred;
        logic [9:0] e_pbt;
        logic [1:0] e_corr;
    } vec_t;

    typedef struct {
        logic       hit;
        logic       pred;
        logic [9:0] pbt;
        logic [1:0] corr;
        logic       flush;
        logic [9:0] epbt;
        logic [9:0] cni;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    // Drive one vector and queue what the outputs must be.
    task automatic drive(input vec_t v);
        exp_t e;
        if_PC = v.if_pc;   id_PC = v.id_pc;   id_branchtarget = v.id_tgt;
        id_is_btype = v.id_b;  id_is_jump = v.id_j;  id_stall = v.id_st;
        exe_valid = v.ev;  exe_PC = v.epc;   exe_pred_taken = v.ep;
        exe_target = v.etgt;  exe_z = v.z;  exe_less = v.less;  exe_btype = v.bt;
        e.hit   = v.e_hit;
        e.pred  = v.e_pred;
        e.pbt   = v.e_pbt;
        e.corr  = v.e_corr;
        e.flush = v.e_corr[1];
        e.epbt  = v.etgt;
        e.cni   = v.epc + 10'd1;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the settled outputs.
    task automatic compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, " if_hit"},         32'(if_hit),         32'(e.hit));
            check({tag, " if_prediction"},  32'(if_prediction),  32'(e.pred));
            check({tag, " if_PBT"},         32'(if_PBT),         32'(e.pbt));
            check({tag, " exe_correction"}, 32'(exe_correction), 32'(e.corr));
            check({tag, " flush"},          32'(flush),          32'(e.flush));
            check({tag, " exe_PBT"},        32'(exe_PBT),        32'(e.epbt));
            check({tag, " exe_CNI"},        32'(exe_CNI),        32'(e.cni));
        end
    endtask

    // One cycle: drive after the edge, compare mid-cycle, then take the edge.
    task automatic run(input vec_t v, input string tag);
        drive(v);
        #3;
        compare(tag);
        @(posedge CLK);
        #1;
    endtask

    task automatic look(input logic [9:0] pc, input logic hit, input logic pred,
                        input logic [9:0] pbt, input string tag);
        vec_t v;
        v = idle();
        v.if_pc = pc;  v.e_hit = hit;  v.e_pred = pred;  v.e_pbt = pbt;
        run(v, tag);
    endtask

    // Allocate a branch not yet in the table; IF probes it in the same cycle.
    task automatic alloc(input logic [9:0] pc, input logic [9:0] tgt, input string tag);
        vec_t v;
        v = idle();
        v.if_pc = pc;  v.id_pc = pc;  v.id_tgt = tgt;  v.id_b = 1'b1;
        run(v, tag);
    endtask

    initial begin
        vec_t v;

        //            if_pc   id_pc   id_tgt  b     j     st    ev    epc     ep    etgt    z     less  bt    hit   pred  pbt     corr
        tbl[0]  = '{10'h025,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,10'h000,1'b0,10'h000,1'b0,1'b0,NONE,1'b0,1'b0,10'h000,2'b00};
        tbl[1]  = '{10'h013,10'h013,10'h040,1'b1,1'b0,1'b0,1'b0,10'h000,1'b0,10'h000,1'b0,1'b0,NONE,1'b0,1'b0,10'h000,2'b00};
        tbl[2]  = '{10'h013,10'h013,10'h040,1'b1,1'b0,1'b0,1'b0,10'h000,1'b0,10'h000,1'b0,1'b0,NONE,1'b1,1'b0,10'h040,2'b00};
        tbl[3]  = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h013,1'b0,10'h040,1'b1,1'b0,BEQ ,1'b1,1'b0,10'h040,2'b11};
        tbl[4]  = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h013,1'b1,10'h040,1'b1,1'b0,BEQ ,1'b1,1'b1,10'h040,2'b00};
        tbl[5]  = tbl[4];
        tbl[6]  = tbl[4];
        tbl[7]  = tbl[4];
        tbl[8]  = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h3FF,1'b1,10'h123,1'b1,1'b0,BNE ,1'b1,1'b1,10'h040,2'b10};
        tbl[9]  = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h013,1'b1,10'h040,1'b0,1'b0,BEQ ,1'b1,1'b1,10'h040,2'b10};
        tbl[10] = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,10'h013,1'b0,10'h040,1'b1,1'b0,BEQ ,1'b1,1'b1,10'h040,2'b00};
        tbl[11] = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h013,1'b0,10'h040,1'b1,1'b0,NONE,1'b1,1'b1,10'h040,2'b00};
        tbl[12] = '{10'h200,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h200,1'b0,10'h300,1'b0,1'b1,BLT ,1'b0,1'b0,10'h000,2'b11};
        tbl[13] = '{10'h200,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h200,1'b1,10'h300,1'b0,1'b1,BGE ,1'b0,1'b0,10'h000,2'b10};
        tbl[14] = '{10'h200,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h200,1'b0,10'h300,1'b0,1'b0,BLTU,1'b0,1'b0,10'h000,2'b00};
        tbl[15] = '{10'h200,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h200,1'b0,10'h300,1'b0,1'b0,BGEU,1'b0,1'b0,10'h000,2'b11};
        tbl[16] = '{10'h013,10'h105,10'h2AA,1'b0,1'b1,1'b0,1'b0,10'h000,1'b0,10'h000,1'b0,1'b0,NONE,1'b1,1'b1,10'h040,2'b00};
        tbl[17] = '{10'h105,10'h107,10'h0AA,1'b1,1'b0,1'b1,1'b0,10'h000,1'b0,10'h000,1'b0,1'b0,NONE,1'b1,1'b1,10'h2AA,2'b00};
        tbl[18] = '{10'h107,10'h106,10'h155,1'b1,1'b1,1'b0,1'b0,10'h000,1'b0,10'h000,1'b0,1'b0,NONE,1'b0,1'b0,10'h000,2'b00};
        tbl[19] = '{10'h106,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,10'h000,1'b0,10'h000,1'b0,1'b0,NONE,1'b1,1'b0,10'h155,2'b00};
        tbl[20] = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h013,1'b1,10'h040,1'b0,1'b0,BEQ ,1'b1,1'b1,10'h040,2'b10};
        tbl[21] = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,10'h000,1'b0,10'h000,1'b0,1'b0,NONE,1'b1,1'b0,10'h040,2'b00};
        tbl[22] = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b1,10'h013,1'b0,10'h040,1'b0,1'b0,BNE ,1'b1,1'b0,10'h040,2'b11};
        tbl[23] = '{10'h013,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,10'h000,1'b0,10'h000,1'b0,1'b0,NONE,1'b1,1'b1,10'h040,2'b00};

        // Reset with idle inputs.
        rst = 1'b1;
        drive(idle());
        void'(sb_q.pop_front());
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;

        // Table: allocation, counter walk with saturation, all branch types,
        // stall suppression, jump/btype init values.
        for (int i = 0; i < 24; i++)
            run(tbl[i], $sformatf("vec%0d", i));

        // FIFO replacement in set 3 (way 0 holds 0x013, pointer at 1).
        alloc(10'h023, 10'h123, "fifo_a2");
        alloc(10'h033, 10'h133, "fifo_a3");
        alloc(10'h043, 10'h143, "fifo_a4");
        alloc(10'h053, 10'h153, "fifo_a5");
        look(10'h013, 1'b0, 1'b0, 10'h000, "fifo_evict1");
        look(10'h023, 1'b1, 1'b0, 10'h123, "fifo_hit2");
        look(10'h033, 1'b1, 1'b0, 10'h133, "fifo_hit3");
        look(10'h043, 1'b1, 1'b0, 10'h143, "fifo_hit4");
        look(10'h053, 1'b1, 1'b0, 10'h153, "fifo_hit5");
        alloc(10'h063, 10'h163, "fifo_a6");
        look(10'h023, 1'b0, 1'b0, 10'h000, "fifo_evict2");
        look(10'h063, 1'b1, 1'b0, 10'h163, "fifo_hit6");

        // Collision: allocation victimises way 2 (0x033) while EXE updates it.
        v = idle();
        v.if_pc = 10'h033;  v.id_pc = 10'h073;  v.id_tgt = 10'h111;  v.id_b = 1'b1;
        v.ev = 1'b1;  v.epc = 10'h033;  v.etgt = 10'h133;  v.z = 1'b1;  v.bt = BEQ;
        v.e_hit = 1'b1;  v.e_pbt = 10'h133;  v.e_corr = 2'b11;
        run(v, "coll_same");
        look(10'h073, 1'b1, 1'b0, 10'h111, "coll_new_entry");
        look(10'h033, 1'b0, 1'b0, 10'h000, "coll_old_gone");

        // Allocation into way 3 and EXE update of way 0 both take effect.
        v = idle();
        v.if_pc = 10'h053;  v.id_pc = 10'h083;  v.id_tgt = 10'h183;  v.id_b = 1'b1;
        v.ev = 1'b1;  v.epc = 10'h053;  v.etgt = 10'h153;  v.z = 1'b1;  v.bt = BEQ;
        v.e_hit = 1'b1;  v.e_pbt = 10'h153;  v.e_corr = 2'b11;
        run(v, "coll_diff");
        look(10'h053, 1'b1, 1'b1, 10'h153, "coll_diff_upd");
        look(10'h083, 1'b1, 1'b0, 10'h183, "coll_diff_alloc");
        look(10'h043, 1'b0, 1'b0, 10'h000, "coll_diff_evict");

        // Reset overrides a same-cycle allocation and invalidates everything.
        v = idle();
        v.if_pc = 10'h083;  v.id_pc = 10'h0A3;  v.id_tgt = 10'h1A3;  v.id_b = 1'b1;
        v.e_hit = 1'b1;  v.e_pbt = 10'h183;
        drive(v);
        rst = 1'b1;
        #3;
        compare("rst_cycle");
        @(posedge CLK);
        #1;
        rst = 1'b0;
        look(10'h0A3, 1'b0, 1'b0, 10'h000, "rst_no_alloc");
        look(10'h083, 1'b0, 1'b0, 10'h000, "rst_clr_083");
        look(10'h105, 1'b0, 1'b0, 10'h000, "rst_clr_105");
        look(10'h053, 1'b0, 1'b0, 10'h000, "rst_clr_053");

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
